// File: rtl/demux3_buf.sv
// 1-to-3 buffered demultiplexer with a one-entry holding register per channel.
// Optional per-channel saturating accept counters are enabled by DEMUX3_STATS_EN.
module demux3_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [2:0]       out_valid,
  input  logic [2:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [7:0]       acc_cnt0,
  output logic [7:0]       acc_cnt1,
  output logic [7:0]       acc_cnt2
);

  logic [1:0]       sel_ch;
  logic             push;
  logic [2:0]       out_valid_q, out_valid_d;
  logic [WIDTH-1:0] data_q [3];
  logic [WIDTH-1:0] data_d [3];

  // Select value 11 aliases channel 2.
  always_comb begin
    sel_ch = 2'd2;
    if (in_sel == 2'b00) begin
      sel_ch = 2'd0;
    end else if (in_sel == 2'b01) begin
      sel_ch = 2'd1;
    end
  end

  assign in_ready = ~reset & (~out_valid_q[sel_ch] | out_ready[sel_ch]);
  assign push     = in_valid & in_ready;

  always_comb begin
    out_valid_d = out_valid_q & ~out_ready;
    data_d      = data_q;
    if (push) begin
      out_valid_d[sel_ch] = 1'b1;
      data_d[sel_ch]      = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 3'b000;
      data_q      <= '{default: '0};
    end else begin
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];

`ifdef DEMUX3_STATS_EN
  logic [7:0] cnt_q [3];
  logic [7:0] cnt_d [3];

  // Counters stick at 255 rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (push && (cnt_q[sel_ch] != 8'hFF)) begin
      cnt_d[sel_ch] = cnt_q[sel_ch] + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign acc_cnt0 = cnt_q[0];
  assign acc_cnt1 = cnt_q[1];
  assign acc_cnt2 = cnt_q[2];
`else
  assign acc_cnt0 = 8'd0;
  assign acc_cnt1 = 8'd0;
  assign acc_cnt2 = 8'd0;
`endif

endmodule
